// File: rtl/hcsr04_pkg.sv
// ---------------------------------------------------------------------------
// hcsr04_pkg
//  Shared types and constants for the HC-SR04 measurement scheduler.
//  state_t   : scheduler FSM states
//  US_PER_CM : echo round-trip time per cm of range
//  DIST_MAX  : saturation value of the 9-bit distance result
//  us_to_cm(): echo microseconds -> saturated centimetres
// ---------------------------------------------------------------------------
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        CALC,
        HOLDOFF
    } state_t;

    localparam int US_PER_CM = 58;
    localparam int DIST_MAX  = 511;
    localparam int DIST_W    = 9;

    function automatic logic [DIST_W-1:0] us_to_cm(input logic [31:0] us);
        logic [31:0] q;
        q = us / 32'(US_PER_CM);
        return (q > 32'(DIST_MAX)) ? DIST_W'(DIST_MAX) : q[DIST_W-1:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// ---------------------------------------------------------------------------
// us_tick_gen
//  Free-running prescaler producing a one-cycle tick every DIV clocks.
//  Counts 0..DIV-1 and ticks on the terminal count; i_clr restarts at 0.
//  Ports:
//   clk    in  clock
//   rst_n  in  async reset, active low
//   i_clr  in  synchronous clear (restart the microsecond phase)
//   o_tick out one-cycle tick on terminal count
// ---------------------------------------------------------------------------
module us_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Not gated by i_clr: the FSM clears on the very tick that ends HOLDOFF.
    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hcsr04_meas_sched.sv
// ---------------------------------------------------------------------------
// hcsr04_meas_sched
//  HC-SR04 measurement scheduler: trigger pulse, echo timing, echo timeout,
//  inter-shot holdoff, single-shot or continuous ranging.
//  Ports:
//   PCLK, PRESETn     clock, async active-low reset
//   start             1-cycle pulse, begins one shot from IDLE
//   cont_en           level, continuous ranging while high
//   echo              sensor echo pin (asynchronous, synchronised here)
//   trig_out          sensor trigger pin
//   busy              high in every state except IDLE
//   done              1-cycle pulse, new result on echo_us/dist_cm
//   timeout           1-cycle pulse, shot aborted, results unchanged
//   echo_us           last valid echo high time in us
//   dist_cm           distance in cm, saturated at 511
//  Build option: define HCSR04_AVG_EN to report the mean of the last four
//  valid distances instead of the latest one.
// ---------------------------------------------------------------------------
module hcsr04_meas_sched #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TRIG_US         = 10,
    parameter int ECHO_TIMEOUT_US = 30000,
    parameter int HOLDOFF_US      = 60000,
    parameter int CNT_W           = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             start,
    input  logic             cont_en,
    input  logic             echo,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] echo_us,
    output logic [8:0]       dist_cm
);

    import hcsr04_pkg::*;

    localparam int               DIV       = CLK_HZ / 1_000_000;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TO_C      = CNT_W'(ECHO_TIMEOUT_US);
    localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_US - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_us_cnt;
    logic [CNT_W-1:0] r_echo_us;
    logic [8:0]       r_dist;
    logic [8:0]       w_dist_raw;
    logic [8:0]       w_dist_new;
    logic             r_echo_s1, r_echo_s2, r_echo_d;
    logic             w_rise, w_fall;
    logic             w_tick, w_tick_clr;
    logic             w_result;

    // ---- echo synchroniser and edge detect --------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            {r_echo_d, r_echo_s2, r_echo_s1} <= 3'b000;
        else
            {r_echo_d, r_echo_s2, r_echo_s1} <= {r_echo_s2, r_echo_s1, echo};
    end

    // Edge-based: an echo already high when WAIT_RISE starts never counts.
    assign w_rise = r_echo_s2 & ~r_echo_d;
    assign w_fall = ~r_echo_s2 & r_echo_d;

    // ---- microsecond tick, phase restarted on every TRIG entry ------------
    assign w_tick_clr = (w_state_nxt == TRIG) && (r_state != TRIG);

    us_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .i_clr (w_tick_clr),
        .o_tick(w_tick)
    );

    // ---- FSM: state register ----------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ---- FSM: next state --------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (start || cont_en) w_state_nxt = TRIG;
            TRIG:      if (w_tick && r_us_cnt == TRIG_LAST) w_state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                if (w_rise)                 w_state_nxt = MEASURE;
                else if (r_us_cnt >= TO_C)  w_state_nxt = HOLDOFF;
            end
            // fall is checked first so a fall on the timeout tick still counts
            MEASURE: begin
                if (w_fall)                 w_state_nxt = CALC;
                else if (r_us_cnt >= TO_C)  w_state_nxt = HOLDOFF;
            end
            CALC:      w_state_nxt = HOLDOFF;
            HOLDOFF:   if (w_tick && r_us_cnt == HO_LAST)
                           w_state_nxt = cont_en ? TRIG : IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs -----------------------------------------------------
    always_comb begin
        trig_out = (r_state == TRIG);
        busy     = (r_state != IDLE);
        done     = (r_state == CALC);
        timeout  = ((r_state == WAIT_RISE) && !w_rise && (r_us_cnt >= TO_C)) ||
                   ((r_state == MEASURE)   && !w_fall && (r_us_cnt >= TO_C));
    end

    // ---- shared microsecond counter ---------------------------------------
    // Cleared on every state change. On the rise cycle a coincident tick is
    // kept so the count covers exactly the synchronised high window.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_us_cnt <= '0;
        else if (r_state != w_state_nxt) begin
            if (r_state == WAIT_RISE && w_state_nxt == MEASURE)
                r_us_cnt <= CNT_W'(w_tick);
            else
                r_us_cnt <= '0;
        end else if (w_tick && r_us_cnt != CNT_MAX)
            r_us_cnt <= r_us_cnt + 1'b1;
    end

    // ---- results: registered on the fall so they are valid during CALC ----
    assign w_result   = (r_state == MEASURE) && (w_state_nxt == CALC);
    assign w_dist_raw = us_to_cm(32'(r_us_cnt));

`ifdef HCSR04_AVG_EN
    // Three previous samples plus the new one; the first result seeds all.
    logic [2:0][8:0] r_win;
    logic            r_seeded;
    logic [10:0]     w_sum;

    assign w_sum = r_seeded ? (11'(w_dist_raw) + 11'(r_win[0]) + 11'(r_win[1]) + 11'(r_win[2]))
                            : {w_dist_raw, 2'b00};
    assign w_dist_new = w_sum[10:2];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_win    <= '0;
            r_seeded <= 1'b0;
        end else if (w_result) begin
            r_win    <= r_seeded ? {r_win[1:0], w_dist_raw} : {3{w_dist_raw}};
            r_seeded <= 1'b1;
        end
    end
`else
    assign w_dist_new = w_dist_raw;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_echo_us <= '0;
            r_dist    <= '0;
        end else if (w_result) begin
            r_echo_us <= r_us_cnt;
            r_dist    <= w_dist_new;
        end
    end

    assign echo_us = r_echo_us;
    assign dist_cm = r_dist;

endmodule

// File: tb/tb_hcsr04_meas_sched.sv
// ---------------------------------------------------------------------------
// tb_hcsr04_meas_sched
//  Scoreboard bench: stimulus pushes expected done/timeout events, a monitor
//  on the falling clock edge pops and compares whenever the DUT reports one.
//  Scaled clock: 2 MHz (2 cycles per us), 2000 us echo timeout, 300 us holdoff.
// ---------------------------------------------------------------------------
module tb_hcsr04_meas_sched;

    localparam int CLK_HZ = 2_000_000;
    localparam int DIV    = 2;
    localparam int TRIG_US = 10;
    localparam int TO_US  = 2000;
    localparam int HO_US  = 300;
    localparam int BOUND  = 20000;

`ifdef HCSR04_AVG_EN
    localparam int T6_CM [4] = '{10, 10, 12, 15};
`else
    localparam int T6_CM [4] = '{10, 10, 20, 20};
`endif
    localparam int T6_US [4] = '{580, 580, 1160, 1160};

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic        echo = 1'b0;
    logic        trig_out, busy, done, timeout;
    logic [15:0] echo_us;
    logic [8:0]  dist_cm;

    always #5 PCLK = ~PCLK;

    hcsr04_meas_sched #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .ECHO_TIMEOUT_US(TO_US),
        .HOLDOFF_US(HO_US), .CNT_W(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .cont_en(cont_en),
        .echo(echo), .trig_out(trig_out), .busy(busy), .done(done),
        .timeout(timeout), .echo_us(echo_us), .dist_cm(dist_cm)
    );

    typedef struct {
        bit is_to;
        int e_us;
        int cm;
        int lat;   // cycles from trig fall to timeout; 0 = not checked
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   trig_fall_cyc = 0;
    int   trig_w = 0;
    bit   trig_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit to, input int e, input int cm, input int lat);
        exp_t x;
        x.is_to = to; x.e_us = e; x.cm = cm; x.lat = lat;
        q.push_back(x);
    endtask

    // ---- monitor ----------------------------------------------------------
    always @(negedge PCLK) begin
        cyc++;
        if (!PRESETn) begin
            trig_w    = 0;
            trig_prev = 1'b0;
        end else begin
            if (trig_out)
                trig_w++;
            else if (trig_prev) begin
                chk("trig_width", trig_w, TRIG_US * DIV);
                trig_w = 0;
                trig_fall_cyc = cyc;
            end
            trig_prev = trig_out;
            if (done || timeout) begin
                if (q.size() == 0)
                    chk("unexpected_event", {30'd0, done, timeout}, 0);
                else begin
                    m_e = q.pop_front();
                    chk("event_is_timeout", timeout, m_e.is_to);
                    chk("echo_us", echo_us, m_e.e_us);
                    chk("dist_cm", dist_cm, m_e.cm);
                    if (m_e.lat > 0)
                        chk("timeout_latency", cyc - trig_fall_cyc, m_e.lat);
                end
            end
        end
    end

    // ---- stimulus helpers -------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_trig_fall();
        int n = 0;
        while (!trig_out && n < BOUND) begin tick(1); n++; end
        while (trig_out && n < BOUND) begin tick(1); n++; end
        chk("trig_seen_in_bound", n < BOUND, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < BOUND) begin tick(1); n++; end
        chk("idle_in_bound", n < BOUND, 1);
    endtask

    task automatic shot(input int wait_us, input int high_us);
        wait_trig_fall();
        tick(wait_us * DIV);
        if (high_us > 0) begin
            echo = 1'b1;
            tick(high_us * DIV);
            echo = 1'b0;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_trig"},    trig_out, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_echo_us"}, echo_us, 0);
        chk({tag, "_dist"},    dist_cm, 0);
    endtask

    // ---- watchdog ---------------------------------------------------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time bound, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---- directed sequence ------------------------------------------------
    initial begin
        tick(3);
        chk_reset_outs("reset");
        PRESETn = 1'b1;
        tick(5);

        // 1: single shot, 1160 us echo after 200 us -> 20 cm
        push(0, 1160, 20, 0);
        pulse_start();
        shot(200, 1160);
        wait_idle();

        // 2: no echo -> timeout 2000 us after trig fall, results unchanged
        push(1, 1160, 20, TO_US * DIV);
        pulse_start();
        wait_trig_fall();
        wait_idle();
        tick(50);
        chk("t2_idle_after_holdoff", busy, 0);

        // 3: echo longer than timeout -> timeout in MEASURE; start in HOLDOFF ignored
        push(1, 1160, 20, 0);
        pulse_start();
        shot(100, 2150);
        chk("t3_busy_in_holdoff", busy, 1);
        pulse_start();
        wait_idle();
        tick(100);
        chk("t3_start_not_queued", busy, 0);

        // 4: continuous ranging, drop cont_en mid third shot -> one more done
        push(0, 580, 10, 0);
        push(0, 580, 10, 0);
        push(0, 580, 10, 0);
        cont_en = 1'b1;
        shot(50, 580);
        shot(50, 580);
        wait_trig_fall();
        tick(100);
        echo = 1'b1;
        tick(200);
        cont_en = 1'b0;
        tick(960);
        echo = 1'b0;
        wait_idle();
        tick(100);
        chk("t4_idle_after_cont_drop", busy, 0);

        // 5: reset during TRIG drops everything at once
        pulse_start();
        begin
            int n = 0;
            while (!trig_out && n < BOUND) begin tick(1); n++; end
            chk("t5_trig_rose", trig_out, 1);
        end
        tick(5);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_reset_outs("mid_shot_reset");
        tick(2);
        PRESETn = 1'b1;
        tick(50);
        chk("t5_idle_after_release", busy, 0);

        // 6: result sequence (averaged when the option is built in)
        for (int i = 0; i < 4; i++) begin
            push(0, T6_US[i], T6_CM[i], 0);
            pulse_start();
            shot(50, T6_US[i]);
            wait_idle();
        end

        tick(20);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
